async_count_sampler: RTL and testbench

ASYNC_COUNT_SAMPLER -- requirements
Module: async_count_sampler

---
 rtl/async_count_sampler.sv | 118 +++++++++++
 tb/tb_async_count_sampler.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/async_count_sampler.sv
// Synchronizes a free-running 4-bit ripple count, qualifies stable values,
// extends them to EXT_W bits and offers handshaked snapshots of the total.
module async_count_sampler #(
    parameter int EXT_W         = 12,
    parameter int STABLE_CYCLES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [3:0]       count_in,
    input  logic             snap_req,
    input  logic             snap_ready,
    output logic             snap_valid,
    output logic [EXT_W-1:0] snap_data,
    output logic [EXT_W-1:0] ext_count,
    output logic             wrap_pulse,
    output logic             ovf
);

    localparam logic [2:0] RUN_MAX = 3'(STABLE_CYCLES);
    localparam logic [2:0] RUN_PRE = 3'(STABLE_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_PRESENT
    } state_t;

    state_t state, state_nxt;

    logic [3:0]       s1, s2, s2_prev, last;
    logic [2:0]       run;
    logic             same, qualify;
    logic [3:0]       delta;
    logic [EXT_W:0]   sum;
    logic             cap;
    logic [EXT_W-1:0] cap_val;

    assign same    = (s2 == s2_prev);
    assign qualify = same && (run == RUN_PRE);
    assign delta   = s2 - last;
    assign sum     = {1'b0, ext_count} + (EXT_W+1)'(delta);

    always_ff @(posedge clk) begin
        if (rst) begin
            s1         <= '0;
            s2         <= '0;
            s2_prev    <= '0;
            run        <= '0;
            last       <= '0;
            ext_count  <= '0;
            wrap_pulse <= 1'b0;
            ovf        <= 1'b0;
        end else begin
            s1         <= count_in;
            s2         <= s1;
            s2_prev    <= s2;
            wrap_pulse <= qualify && (s2 < last);
            if (!same) begin
                run <= '0;
            end else if (run != RUN_MAX) begin
                run <= run + 3'd1;
            end
            if (qualify) begin
                last      <= s2;
                ext_count <= sum[EXT_W-1:0];
                if (sum[EXT_W]) begin
                    ovf <= 1'b1;
                end
            end
        end
    end

    // A capture in WAIT takes the post-update total when a qualify lands,
    // or the current total immediately if the count is already settled.
    always_comb begin
        state_nxt = state;
        cap       = 1'b0;
        cap_val   = ext_count;
        unique case (state)
            S_IDLE: begin
                if (snap_req) begin
                    state_nxt = S_WAIT;
                end
            end
            S_WAIT: begin
                if (qualify) begin
                    cap       = 1'b1;
                    cap_val   = sum[EXT_W-1:0];
                    state_nxt = S_PRESENT;
                end else if (run == RUN_MAX) begin
                    cap       = 1'b1;
                    state_nxt = S_PRESENT;
                end
            end
            S_PRESENT: begin
                if (snap_ready) begin
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            snap_data <= '0;
        end else begin
            state <= state_nxt;
            if (cap) begin
                snap_data <= cap_val;
            end
        end
    end

    assign snap_valid = (state == S_PRESENT);

endmodule

// File: tb/tb_async_count_sampler.sv
// Randomized and directed checks of async_count_sampler against a
// run-length based reference model of the count extension and snapshot.
module tb_async_count_sampler;

    localparam int S = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  count_in;
    logic        snap_req;
    logic        snap_ready;
    logic        snap_valid;
    logic [11:0] snap_data;
    logic [11:0] ext_count;
    logic        wrap_pulse;
    logic        ovf;

    logic        snap_valid4;
    logic [3:0]  snap_data4;
    logic [3:0]  ext_count4;
    logic        wrap_pulse4;
    logic        ovf4;

    int n_checks = 0;
    int n_fail   = 0;
    int wraps    = 0;

    async_count_sampler #(.EXT_W(12), .STABLE_CYCLES(S)) dut (
        .clk(clk), .rst(rst), .count_in(count_in),
        .snap_req(snap_req), .snap_ready(snap_ready),
        .snap_valid(snap_valid), .snap_data(snap_data),
        .ext_count(ext_count), .wrap_pulse(wrap_pulse), .ovf(ovf)
    );

    async_count_sampler #(.EXT_W(4), .STABLE_CYCLES(S)) dut4 (
        .clk(clk), .rst(rst), .count_in(count_in),
        .snap_req(1'b0), .snap_ready(1'b0),
        .snap_valid(snap_valid4), .snap_data(snap_data4),
        .ext_count(ext_count4), .wrap_pulse(wrap_pulse4), .ovf(ovf4)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (wrap_pulse) wraps++;

    // Reference: a value qualifies when the synchronized stream has shown it
    // for S+1 consecutive cycles; total counts every qualified step since reset.
    typedef enum int {M_IDLE, M_WAIT, M_PRESENT} mstate_t;
    mstate_t    m_state;
    logic [3:0] m_vis, m_s1, m_last;
    int         m_run, m_prev_run, m_total;
    logic       m_wrap;
    logic [11:0] m_snap, m_ext_now;
    logic       m_qual, m_full;

    always @(posedge clk) begin
        if (rst) begin
            m_vis = 0; m_s1 = 0; m_last = 0;
            m_run = 2; m_prev_run = 1; m_total = 0;
            m_wrap = 0; m_snap = 0; m_state = M_IDLE;
        end else begin
            m_qual    = (m_run == S + 1);
            m_full    = (m_prev_run >= S + 1);
            m_ext_now = 12'(m_total);
            m_wrap    = 0;
            if (m_qual) begin
                m_wrap  = (m_vis < m_last);
                m_total = m_total + int'(4'(m_vis - m_last));
                m_last  = m_vis;
            end
            case (m_state)
                M_IDLE: if (snap_req) m_state = M_WAIT;
                M_WAIT: begin
                    if (m_qual) begin
                        m_snap = 12'(m_total); m_state = M_PRESENT;
                    end else if (m_full) begin
                        m_snap = m_ext_now; m_state = M_PRESENT;
                    end
                end
                default: if (snap_ready) m_state = M_IDLE;
            endcase
            m_prev_run = m_run;
            m_run = (m_s1 == m_vis) ? ((m_run < 15) ? m_run + 1 : 15) : 1;
            m_vis = m_s1;
            m_s1  = count_in;
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; snap_req = 1'b0; snap_ready = 1'b0; count_in = 4'h0;
        cyc(2);
        rst = 1'b0;
        wraps = 0;
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++;
        if ({ext_count, snap_data, snap_valid, wrap_pulse, ovf} !== 27'd0) begin
            n_fail++;
            $display("FAIL reset_state: ext=%0d data=%0d v=%b w=%b o=%b want all 0",
                     ext_count, snap_data, snap_valid, wrap_pulse, ovf);
        end
        cyc(20);
        n_checks++;
        if (ext_count !== 12'd0 || wraps != 0) begin
            n_fail++;
            $display("FAIL hold_zero: ext=%0d wraps=%0d want 0 0", ext_count, wraps);
        end
    endtask

    task automatic test_sweep();
        do_reset();
        for (int i = 1; i <= 17; i++) begin
            count_in = 4'(i);
            cyc(6);
        end
        cyc(6);
        n_checks++;
        if (ext_count !== 12'd17) begin
            n_fail++;
            $display("FAIL sweep_ext: got %0d want 17", ext_count);
        end
        n_checks++;
        if (wraps != 1) begin
            n_fail++;
            $display("FAIL sweep_wraps: got %0d want 1", wraps);
        end
    endtask

    task automatic test_glitch();
        do_reset();
        count_in = 4'h3; cyc(6);
        count_in = 4'h7; cyc(1);
        count_in = 4'h4; cyc(8);
        n_checks++;
        if (ext_count !== 12'd4 || wraps != 0) begin
            n_fail++;
            $display("FAIL glitch: ext=%0d wraps=%0d want 4 0", ext_count, wraps);
        end
    endtask

    task automatic test_jump();
        do_reset();
        count_in = 4'hE; cyc(6);
        n_checks++;
        if (ext_count !== 12'd14) begin
            n_fail++;
            $display("FAIL jump_pre: got %0d want 14", ext_count);
        end
        count_in = 4'h2; cyc(8);
        n_checks++;
        if (ext_count !== 12'd18 || wraps != 1) begin
            n_fail++;
            $display("FAIL jump: ext=%0d wraps=%0d want 18 1", ext_count, wraps);
        end
    endtask

    task automatic test_snapshot();
        logic [11:0] held;
        int          k;
        do_reset();
        count_in = 4'h5; cyc(8);
        snap_req = 1'b1; cyc(1);
        snap_req = 1'b0;
        k = 0;
        while (!snap_valid && k < 20) begin
            cyc(1);
            k++;
        end
        n_checks++;
        if (!snap_valid) begin
            n_fail++;
            $display("FAIL snap_timeout: valid=%b want 1", snap_valid);
        end
        held = snap_data;
        n_checks++;
        if (snap_data !== 12'd5) begin
            n_fail++;
            $display("FAIL snap_value: got %0d want 5", snap_data);
        end
        count_in = 4'h9;
        for (int i = 0; i < 8; i++) begin
            if (i == 3) snap_req = 1'b1;
            cyc(1);
            snap_req = 1'b0;
            n_checks++;
            if (!snap_valid || snap_data !== held) begin
                n_fail++;
                $display("FAIL snap_hold: v=%b data=%0d want 1 %0d",
                         snap_valid, snap_data, held);
            end
        end
        n_checks++;
        if (ext_count !== 12'd9) begin
            n_fail++;
            $display("FAIL snap_ext_adv: got %0d want 9", ext_count);
        end
        snap_ready = 1'b1; cyc(1);
        snap_ready = 1'b0;
        n_checks++;
        if (snap_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL snap_release: valid=%b want 0", snap_valid);
        end
        cyc(10);
        n_checks++;
        if (snap_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL snap_ignored_req: valid=%b want 0", snap_valid);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        count_in = 4'h6; cyc(8);
        snap_req = 1'b1; cyc(1);
        snap_req = 1'b0; cyc(4);
        rst = 1'b1; cyc(1);
        rst = 1'b0;
        n_checks++;
        if (snap_valid !== 1'b0 || ext_count !== 12'd0) begin
            n_fail++;
            $display("FAIL reset_mid: v=%b ext=%0d want 0 0", snap_valid, ext_count);
        end
    endtask

    task automatic test_random();
        int hold;
        do_reset();
        hold = 0;
        for (int i = 0; i < 400; i++) begin
            if (hold == 0) begin
                count_in = 4'($urandom_range(0, 15));
                hold = $urandom_range(1, 6);
            end
            hold--;
            snap_req   = ($urandom_range(0, 7) == 0);
            snap_ready = ($urandom_range(0, 3) == 0);
            cyc(1);
            n_checks++;
            if (ext_count !== 12'(m_total) || ext_count4 !== 4'(m_total)
                || wrap_pulse !== m_wrap || ovf !== (m_total > 4095)
                || snap_valid !== (m_state == M_PRESENT)
                || (snap_valid && snap_data !== m_snap)) begin
                n_fail++;
                $display("FAIL random[%0d]: ext=%0d/%0d e4=%0d w=%b/%b v=%b/%b d=%0d/%0d",
                         i, ext_count, 12'(m_total), ext_count4, wrap_pulse,
                         m_wrap, snap_valid, m_state == M_PRESENT,
                         snap_data, m_snap);
            end
        end
        snap_req = 1'b0; snap_ready = 1'b0;
    endtask

    task automatic test_ovf();
        do_reset();
        for (int i = 1; i <= 20; i++) begin
            count_in = 4'(i);
            cyc(6);
        end
        cyc(6);
        n_checks++;
        if (ext_count4 !== 4'd4 || ovf4 !== 1'b1) begin
            n_fail++;
            $display("FAIL ovf_narrow: ext=%0d ovf=%b want 4 1", ext_count4, ovf4);
        end
        n_checks++;
        if (ext_count !== 12'd20 || ovf !== 1'b0) begin
            n_fail++;
            $display("FAIL ovf_wide: ext=%0d ovf=%b want 20 0", ext_count, ovf);
        end
        cyc(10);
        n_checks++;
        if (ovf4 !== 1'b1) begin
            n_fail++;
            $display("FAIL ovf_sticky: ovf=%b want 1", ovf4);
        end
        do_reset();
        n_checks++;
        if (ovf4 !== 1'b0 || ext_count4 !== 4'd0) begin
            n_fail++;
            $display("FAIL ovf_reset: ovf=%b ext=%0d want 0 0", ovf4, ext_count4);
        end
    endtask

    initial begin
        rst = 1'b1; count_in = 4'h0; snap_req = 1'b0; snap_ready = 1'b0;
        test_reset();
        test_sweep();
        test_glitch();
        test_jump();
        test_snapshot();
        test_reset_mid();
        test_random();
        test_ovf();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
